// File: rtl/ship_input_decoder.sv
// rtl/ship_input_decoder.sv - PS/2 keyboard receiver mapping arrows/WASD to ship move pulses
module ship_input_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       frame_tick,
    output logic       move_left,
    output logic       move_right,
    output logic       move_up,
    output logic       move_down,
    output logic [3:0] key_held,
    output logic       rx_error
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [7:0]    held_q, held_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          rx_error_q, rx_error_d;
    logic [3:0]    move_q, move_d;

    logic       fall;
    logic       bit_in;
    logic       map_hit;
    logic [2:0] map_idx;
    logic [3:0] kh;

    // held_q[3:0] are arrow keys, held_q[7:4] are WASD; both ordered {down,up,right,left}
    assign kh = held_q[3:0] | held_q[7:4];

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        held_d      = held_q;
        to_cnt_d    = '0;
        rx_error_d  = 1'b0;
        move_d      = 4'b0000;
        fall        = 1'b0;
        bit_in      = data_sync_q[1];
        map_hit     = 1'b0;
        map_idx     = 3'd0;

        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
                fall   = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end

        if (state_q != IDLE) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (fall) begin
            to_cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = bit_in;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!(bit_in && (^{shift_q, parity_q}))) begin
                        rx_error_d = 1'b1;
                        ext_d      = 1'b0;
                        brk_d      = 1'b0;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        if (ext_q) begin
                            case (shift_q)
                                8'h6B: begin map_hit = 1'b1; map_idx = 3'd0; end
                                8'h74: begin map_hit = 1'b1; map_idx = 3'd1; end
                                8'h75: begin map_hit = 1'b1; map_idx = 3'd2; end
                                8'h72: begin map_hit = 1'b1; map_idx = 3'd3; end
                                default: ;
                            endcase
                        end else begin
                            case (shift_q)
                                8'h1C: begin map_hit = 1'b1; map_idx = 3'd4; end
                                8'h23: begin map_hit = 1'b1; map_idx = 3'd5; end
                                8'h1D: begin map_hit = 1'b1; map_idx = 3'd6; end
                                8'h1B: begin map_hit = 1'b1; map_idx = 3'd7; end
                                default: ;
                            endcase
                        end
                        if (map_hit) begin
                            held_d[map_idx] = ~brk_q;
                        end
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d    = IDLE;
            rx_error_d = 1'b1;
            to_cnt_d   = '0;
        end

        // Decision uses the held state registered before this edge
        if (frame_tick) begin
            move_d = {kh[3] & ~kh[2], kh[2] & ~kh[3], kh[1] & ~kh[0], kh[0] & ~kh[1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            held_q      <= 8'h00;
            to_cnt_q    <= '0;
            rx_error_q  <= 1'b0;
            move_q      <= 4'b0000;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            held_q      <= held_d;
            to_cnt_q    <= to_cnt_d;
            rx_error_q  <= rx_error_d;
            move_q      <= move_d;
        end
    end

    assign key_held   = kh;
    assign rx_error   = rx_error_q;
    assign move_left  = move_q[0];
    assign move_right = move_q[1];
    assign move_up    = move_q[2];
    assign move_down  = move_q[3];
endmodule

// File: tb/tb_ship_input_decoder.sv
// tb/tb_ship_input_decoder.sv - randomized self-checking bench for ship_input_decoder
module tb_ship_input_decoder;
    localparam int FL = 4;
    localparam int TO = 200;
    localparam int HP = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       frame_tick;
    logic       move_left, move_right, move_up, move_down;
    logic [3:0] key_held;
    logic       rx_error;

    ship_input_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .frame_tick(frame_tick), .move_left(move_left), .move_right(move_right),
        .move_up(move_up), .move_down(move_down), .key_held(key_held), .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int exp_err = 0;
    int mvl_cnt = 0;
    int mvr_cnt = 0;
    bit stable = 0;
    bit tick_pending = 0;
    logic [7:0] m_arrow = 8'h00;
    logic [7:0] m_wasd = 8'h00;
    bit m_ext = 0;
    bit m_brk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_kh();
        return m_arrow[3:0] | m_wasd[3:0];
    endfunction

    function automatic logic [3:0] m_move();
        logic [3:0] k;
        k = m_kh();
        return {k[3] && !k[2], k[2] && !k[3], k[1] && !k[0], k[0] && !k[1]};
    endfunction

    // Reference: what one received byte does to the keyboard state
    task automatic model_byte(input logic [7:0] b, input bit ok);
        int d;
        if (!ok) begin
            exp_err++;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            d = -1;
            if (m_ext) begin
                if (b == 8'h6B) d = 0;
                if (b == 8'h74) d = 1;
                if (b == 8'h75) d = 2;
                if (b == 8'h72) d = 3;
                if (d >= 0) m_arrow[d] = !m_brk;
            end else begin
                if (b == 8'h1C) d = 0;
                if (b == 8'h23) d = 1;
                if (b == 8'h1D) d = 2;
                if (b == 8'h1B) d = 3;
                if (d >= 0) m_wasd[d] = !m_brk;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (rx_error) err_cnt++;
            if (move_left) mvl_cnt++;
            if (move_right) mvr_cnt++;
            chk("move", {28'd0, move_down, move_up, move_right, move_left},
                {28'd0, tick_pending ? m_move() : 4'b0000});
            if (stable) chk("key_held", {28'd0, key_held}, {28'd0, m_kh()});
            tick_pending = frame_tick;
        end else begin
            tick_pending = 0;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            wait_cyc(HP);
            ps2_clk = 1'b0;
            wait_cyc(HP);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        logic par;
        stable = 0;
        par = ~(^b) ^ bad;
        send_bits({1'b1, par, b, 1'b0}, 11);
        ps2_data = 1'b1;
        wait_cyc(30);
        model_byte(b, !bad);
        chk("rx_error_count", err_cnt, exp_err);
        stable = 1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            wait_cyc(3);
            frame_tick = 1'b1;
            wait_cyc(1);
            frame_tick = 1'b0;
            wait_cyc(2);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int l0, r0, e0;
        logic [7:0] pool [10];
        logic [7:0] b;
        pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h1C, 8'h23, 8'h1D, 8'h1B};
        reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; frame_tick = 1'b0;
        wait_cyc(3);
        chk("reset_key_held", {28'd0, key_held}, 0);
        chk("reset_rx_error", {31'd0, rx_error}, 0);
        chk("reset_move", {28'd0, move_down, move_up, move_right, move_left}, 0);
        reset = 1'b1;
        wait_cyc(5);
        stable = 1;

        send_byte(8'hE0, 0); send_byte(8'h6B, 0);
        chk("e0_6b_held", {28'd0, key_held}, 32'h1);
        l0 = mvl_cnt;
        tick(3);
        chk("left_pulses", mvl_cnt - l0, 3);

        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h6B, 0);
        chk("break_left", {28'd0, key_held}, 32'h0);
        tick(1);

        send_byte(8'h1C, 0); send_byte(8'hE0, 0); send_byte(8'h74, 0);
        chk("left_right_held", {28'd0, key_held}, 32'h3);
        l0 = mvl_cnt; r0 = mvr_cnt;
        tick(1);
        chk("lr_cancel", (mvl_cnt - l0) + (mvr_cnt - r0), 0);
        send_byte(8'hF0, 0); send_byte(8'h1C, 0);
        r0 = mvr_cnt;
        tick(1);
        chk("right_after_a_release", mvr_cnt - r0, 1);

        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h74, 0);
        e0 = err_cnt;
        send_byte(8'h75, 1);
        chk("parity_err_pulse", err_cnt - e0, 1);
        chk("parity_err_held", {28'd0, key_held}, 32'h0);
        send_byte(8'hE0, 0); send_byte(8'h75, 0);
        chk("up_held", {28'd0, key_held}, 32'h4);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);

        stable = 0;
        e0 = err_cnt;
        send_bits(11'b000_0000_1010, 4);
        wait_cyc(TO + 60);
        exp_err++;
        chk("timeout_err_pulse", err_cnt - e0, 1);
        stable = 1;
        send_byte(8'hE0, 0); send_byte(8'h72, 0);
        chk("down_after_timeout", {28'd0, key_held}, 32'h8);

        e0 = err_cnt;
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        wait_cyc(FL - 1);
        ps2_clk = 1'b1;
        wait_cyc(20);
        ps2_data = 1'b1;
        wait_cyc(5);
        send_byte(8'h1D, 0);
        chk("glitch_ignored_held", {28'd0, key_held}, 32'hC);
        chk("glitch_no_err", err_cnt - e0, 0);

        stable = 0;
        send_bits(11'b000_1110_0100, 5);
        reset = 1'b0;
        wait_cyc(2);
        chk("midreset_key_held", {28'd0, key_held}, 0);
        chk("midreset_rx_error", {31'd0, rx_error}, 0);
        chk("midreset_move", {28'd0, move_down, move_up, move_right, move_left}, 0);
        m_arrow = 0; m_wasd = 0; m_ext = 0; m_brk = 0;
        ps2_data = 1'b1;
        reset = 1'b1;
        wait_cyc(5);
        stable = 1;
        send_byte(8'h23, 0);
        chk("after_reset_right", {28'd0, key_held}, 32'h2);

        for (int i = 0; i < 120; i++) begin
            int k;
            k = $urandom_range(0, 11);
            b = (k < 10) ? pool[k] : 8'($urandom);
            send_byte(b, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ship_input_decoder.md
SHIP_INPUT_DECODER -- requirements
Module: ship_input_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive clk samples required to accept a new ps2_clk level.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port ps2_clk  input  1  PS/2 device clock; asynchronous to clk.
REQ-006 Port ps2_data  input  1  PS/2 device data; asynchronous to clk.
REQ-007 Port frame_tick  input  1  one-clk pulse per video frame.
REQ-008 Ports move_left, move_right, move_up, move_down  output  1 each  one-clk movement request pulses for ship_controller.
REQ-009 Port key_held  output  4  current held state, bit order {down,up,right,left}.
REQ-010 Port rx_error  output  1  one-clk pulse on a rejected PS/2 frame.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before use.
REQ-012 Synchronized ps2_clk SHALL change filtered level only after FILTER_LEN consecutive equal samples differing from the current filtered level.
REQ-013 A bit SHALL be sampled from synchronized ps2_data in the cycle a filtered ps2_clk falling edge is detected.
REQ-014 Receiver FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: sampled 0 -> DATA with bit counter 0; sampled 1 -> stay IDLE, no error.
REQ-016 DATA: shift bit in LSB-first; after the 8th bit -> PARITY.
REQ-017 PARITY: store bit -> STOP.
REQ-018 STOP: byte accepted iff stop bit = 1 and the 8 data bits plus parity bit have odd parity; always -> IDLE.
REQ-019 Rejected byte SHALL pulse rx_error for exactly one cycle, clear the E0/F0 prefix flags, and leave key_held unchanged.
REQ-020 In DATA, PARITY or STOP, TIMEOUT_CYCLES cycles without a falling edge SHALL return the FSM to IDLE, discard the partial byte, and pulse rx_error.
REQ-021 Accepted 0xE0 SHALL set the ext flag; accepted 0xF0 SHALL set the brk flag; neither changes key_held.
REQ-022 Any other accepted byte SHALL be decoded using the current ext/brk flags; both flags SHALL then clear in the same cycle.
REQ-023 Key map with ext=1: 0x6B left, 0x74 right, 0x75 up, 0x72 down.
REQ-024 Key map with ext=0: 0x1C left (A), 0x23 right (D), 0x1D up (W), 0x1B down (S).
REQ-025 Arrow and WASD keys SHALL be tracked as 8 independent held bits; key_held[i] = arrow bit OR WASD bit for direction i.
REQ-026 Mapped code with brk=0 SHALL set its held bit; with brk=1 SHALL clear it; unmapped codes SHALL be ignored with no error.
REQ-027 key_held SHALL reflect a decoded make/break in the cycle after the stop-bit sample.
REQ-028 On each frame_tick, each move_* output SHALL assert for exactly the following cycle iff its key_held bit is 1 and the opposite-direction bit is 0.
REQ-029 If left and right are both held, move_left and move_right SHALL both stay 0; the same rule applies to up and down.
REQ-030 move_* SHALL be 0 in every cycle not immediately following a frame_tick.
REQ-031 A key_held update and a frame_tick in the same cycle: the move decision SHALL use key_held as registered before that edge.

Reset
REQ-032 While reset is low: FSM = IDLE, bit counter = 0, shift register = 0, ext/brk = 0, all 8 held bits = 0, filtered ps2_clk = 1, timeout counter = 0.
REQ-033 While reset is low: move_* = 0, key_held = 0, rx_error = 0.
REQ-034 Reset asserted mid-frame SHALL discard the partial byte; reception SHALL restart at the next start bit after reset release.

Verification
REQ-035 Send E0 6B, then frame_tick x3 -> key_held=4'b0001; move_left pulses once after each tick; other move_* = 0.
REQ-036 Send E0 F0 6B, then frame_tick -> key_held=0; no move_* pulse.
REQ-037 Send 1C (A) and E0 74 (right), then frame_tick -> key_held=4'b0011; move_left=move_right=0. Send F0 1C, then frame_tick -> move_right pulses.
REQ-038 Send 0x75 with even parity, then E0 75 -> first frame pulses rx_error with key_held unchanged; second frame gives key_held=4'b0100.
REQ-039 Send start bit plus 3 data bits, stall > TIMEOUT_CYCLES, then send E0 72 -> rx_error pulses once; key_held=4'b1000.
REQ-040 Pulse ps2_clk low for FILTER_LEN-1 cycles -> no bit sampled; FSM stays IDLE. Assert reset mid-byte -> all outputs 0.
